logic_issue: RTL and testbench
==============================

Name: logic_issue

Overview:
- Decode/issue stage that drives the logic unit's operand and opcode inputs (logic_A, logic_B, logic_op) from RV32I instructions.
- Decodes OP and OP-IMM AND/OR/XOR, selects register or sign-extended immediate for operand B, and registers the result into a 2-entry skid buffer.
- Sits between register-file read and the execute stage. Both sides use valid/ready handshakes.

Parameters:
- XLEN, 32, operand and instruction width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  upstream instruction valid.
- instr_ready  out  1  stage can accept this cycle.
- instr  in  32  raw instruction word.
- rs1_data  in  32  register-file value for rs1.
- rs2_data  in  32  register-file value for rs2.
- ex_valid  out  1  issued operation valid.
- ex_ready  in  1  execute stage accepts.
- logic_A  out  32  operand A, fed to the logic unit.
- logic_B  out  32  operand B, fed to the logic unit.
- logic_op  out  2  00 AND, 01 OR, 10 XOR, 11 none (unit outputs zero).
- rd_addr  out  5  destination register, instr[11:7].
- illegal  out  1  issued word was not a supported logic instruction.

Behaviour:
- Clock/reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - While rst=1, instr_ready=0 and no transfer occurs.
  - After the first clk edge with rst=1, every output register is 0: ex_valid=0, logic_A=0, logic_B=0, logic_op=00, rd_addr=0, illegal=0, skid entry empty.
  - Reset asserted mid-operation discards both buffered entries; nothing is replayed.
- Handshake:
  - Accept on instr_valid & instr_ready. Issue on ex_valid & ex_ready.
  - Latency is exactly 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
  - Outputs are held stable while ex_valid & !ex_ready.
  - Order is strictly preserved; no bubbles are inserted while both sides are ready, giving 1 op/cycle throughput.
- Skid buffer:
  - Two registers: main (drives the outputs) and skid.
  - instr_ready = !skid_full & !rst, taken from a register; there is no combinational path from ex_ready.
  - Accept while main is full and not issuing: the entry goes to skid, skid_full=1, instr_ready drops the next cycle.
  - Issue while skid is full: skid moves to main. A new accept in that same cycle is impossible because ready=0.
  - Simultaneous accept and issue with skid empty: the new entry replaces main.
  - Skid full (2 entries held) is the full boundary. Both empty gives ex_valid=0.
- Decode (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - OP 0110011 with f7=0000000: f3 111 gives op 00, 110 gives 01, 100 gives 10. logic_B = rs2_data.
  - OP-IMM 0010011 with f3 111/110/100: same op mapping. logic_B = sign-extend(instr[31:20]) to 32 bits. f7 is ignored.
  - For all valid forms, logic_A = rs1_data, sampled at accept.
  - Any other word is still accepted and issued with logic_op=11, illegal=1, logic_A = logic_B = 0, rd_addr = instr[11:7].
  - rs1_data and rs2_data are sampled only at accept; later changes do not affect buffered entries.

Optional Feature:
- LOGIC_ISSUE_INVB_EN (Zbb ANDN/ORN/XNOR):
  - Defined: OP with f7=0100000 and f3 111/110/100 decodes to op 00/01/10 with logic_B = ~rs2_data and illegal=0.
  - Undefined: those encodings are illegal (logic_op=11, illegal=1).
  - Latency and handshake are identical either way.

Test Plan:
- Reset: hold rst=1 for 2 cycles with instr_valid=1 → instr_ready=0, ex_valid=0, all outputs 0; instr_ready=1 one cycle after rst drops.
- AND R-type: instr=0x0020F1B3 (and x3,x1,x2), rs1=0xF0F0F0F0, rs2=0x0FF00FF0, ex_ready=1 → next cycle ex_valid=1, op=00, A=0xF0F0F0F0, B=0x0FF00FF0, rd=3, illegal=0.
- XORI negative immediate: instr=0xFFF0C093 (xori x1,x1,-1), rs1=0x12345678 → op=10, B=0xFFFFFFFF, rd=1.
- Backpressure: 3 back-to-back valid ORs with ex_ready=0 → first in main, second in skid, instr_ready=0 on the third. Then ex_ready=1 → all three issue in order, one per cycle, values unchanged.
- Illegal word: instr=0x00000013 with funct3 changed to 001 (slli) → issued, op=11, illegal=1, A=B=0. With LOGIC_ISSUE_INVB_EN, 0x4020F1B3 → op=00, B=~rs2; without the macro → illegal=1.
- Mid-operation reset: both entries full, pulse rst for 1 cycle → ex_valid=0 next cycle, nothing re-issued afterward.

Source files
------------

// File: rtl/logic_issue.sv
// Decode/issue stage feeding the logic unit (AND/OR/XOR) through a 2-entry skid buffer.
// Optional macro LOGIC_ISSUE_INVB_EN enables Zbb ANDN/ORN/XNOR (operand B inverted).
module logic_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] logic_A,
  output logic [XLEN-1:0] logic_B,
  output logic [1:0]      logic_op,
  output logic [4:0]      rd_addr,
  output logic            illegal
);

  localparam int unsigned IMM_W = 12;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
`ifdef LOGIC_ISSUE_INVB_EN
  localparam logic [6:0] F7_INVB    = 7'b0100000;
`endif

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [1:0]      w_f3_op;
  logic            w_f3_ok;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_dec_a;
  logic [XLEN-1:0] w_dec_b;
  logic [1:0]      w_dec_op;
  logic            w_dec_ill;
  logic            w_accept;
  logic            w_issue;
  logic            w_unused;

  logic            r_ready;
  logic            r_main_valid;
  logic [XLEN-1:0] r_main_a;
  logic [XLEN-1:0] r_main_b;
  logic [1:0]      r_main_op;
  logic [4:0]      r_main_rd;
  logic            r_main_ill;
  logic            r_skid_full;
  logic [XLEN-1:0] r_skid_a;
  logic [XLEN-1:0] r_skid_b;
  logic [1:0]      r_skid_op;
  logic [4:0]      r_skid_rd;
  logic            r_skid_ill;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_imm    = {{(XLEN-IMM_W){instr[31]}}, instr[31:20]};
  assign w_unused = ^instr[19:15];

  // funct3 to logic-unit opcode
  always_comb begin
    w_f3_op = 2'b11;
    w_f3_ok = 1'b1;
    case (w_f3)
      3'b111:  w_f3_op = 2'b00;
      3'b110:  w_f3_op = 2'b01;
      3'b100:  w_f3_op = 2'b10;
      default: w_f3_ok = 1'b0;
    endcase
  end

  // Operand/opcode decode; unsupported words become a zero-operand "none" op
  always_comb begin
    w_dec_a   = '0;
    w_dec_b   = '0;
    w_dec_op  = 2'b11;
    w_dec_ill = 1'b1;
    if (w_f3_ok) begin
      if (w_opcode == OPC_OP && w_f7 == F7_BASE) begin
        w_dec_a   = rs1_data;
        w_dec_b   = rs2_data;
        w_dec_op  = w_f3_op;
        w_dec_ill = 1'b0;
      end
`ifdef LOGIC_ISSUE_INVB_EN
      else if (w_opcode == OPC_OP && w_f7 == F7_INVB) begin
        w_dec_a   = rs1_data;
        w_dec_b   = ~rs2_data;
        w_dec_op  = w_f3_op;
        w_dec_ill = 1'b0;
      end
`endif
      else if (w_opcode == OPC_OP_IMM) begin
        w_dec_a   = rs1_data;
        w_dec_b   = w_imm;
        w_dec_op  = w_f3_op;
        w_dec_ill = 1'b0;
      end
    end
  end

  assign w_accept = instr_valid & r_ready;
  assign w_issue  = r_main_valid & ex_ready;

  // Main/skid buffer; ready is registered so ex_ready never reaches instr_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_main_valid <= 1'b0;
      r_main_a     <= '0;
      r_main_b     <= '0;
      r_main_op    <= 2'b00;
      r_main_rd    <= 5'd0;
      r_main_ill   <= 1'b0;
      r_skid_full  <= 1'b0;
      r_skid_a     <= '0;
      r_skid_b     <= '0;
      r_skid_op    <= 2'b00;
      r_skid_rd    <= 5'd0;
      r_skid_ill   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (r_skid_full) begin
        if (w_issue) begin
          r_main_a    <= r_skid_a;
          r_main_b    <= r_skid_b;
          r_main_op   <= r_skid_op;
          r_main_rd   <= r_skid_rd;
          r_main_ill  <= r_skid_ill;
          r_skid_full <= 1'b0;
        end else begin
          r_ready <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_main_valid || w_issue) begin
          r_main_valid <= 1'b1;
          r_main_a     <= w_dec_a;
          r_main_b     <= w_dec_b;
          r_main_op    <= w_dec_op;
          r_main_rd    <= instr[11:7];
          r_main_ill   <= w_dec_ill;
        end else begin
          r_skid_full <= 1'b1;
          r_skid_a    <= w_dec_a;
          r_skid_b    <= w_dec_b;
          r_skid_op   <= w_dec_op;
          r_skid_rd   <= instr[11:7];
          r_skid_ill  <= w_dec_ill;
          r_ready     <= 1'b0;
        end
      end else if (w_issue) begin
        r_main_valid <= 1'b0;
      end
    end
  end

  assign instr_ready = r_ready;
  assign ex_valid    = r_main_valid;
  assign logic_A     = r_main_a;
  assign logic_B     = r_main_b;
  assign logic_op    = r_main_op;
  assign rd_addr     = r_main_rd;
  assign illegal     = r_main_ill;

endmodule

// File: tb/tb_logic_issue.sv
// Self-checking bench for logic_issue: directed steps plus random traffic against a queue model.
module tb_logic_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [31:0] logic_A;
  logic [31:0] logic_B;
  logic [1:0]  logic_op;
  logic [4:0]  rd_addr;
  logic        illegal;

  logic_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .logic_A(logic_A), .logic_B(logic_B), .logic_op(logic_op),
    .rd_addr(rd_addr), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef LOGIC_ISSUE_INVB_EN
  localparam bit INVB = 1'b1;
`else
  localparam bit INVB = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  bit   m_ready = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference decode straight from the instruction-set rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   opn;
    int   opcode = int'(ins[6:0]);
    int   f3 = int'(ins[14:12]);
    int   f7 = int'(ins[31:25]);
    opn = (f3 == 7) ? 0 : (f3 == 6) ? 1 : (f3 == 4) ? 2 : -1;
    e = '{a: 32'd0, b: 32'd0, op: 2'd3, rd: ins[11:7], ill: 1'b1};
    if (opn >= 0) begin
      if (opcode == 'h33 && f7 == 0) begin
        e.a = a; e.b = b; e.op = 2'(opn); e.ill = 1'b0;
      end else if (opcode == 'h33 && f7 == 'h20 && INVB) begin
        e.a = a; e.b = ~b; e.op = 2'(opn); e.ill = 1'b0;
      end else if (opcode == 'h13) begin
        e.a = a; e.b = 32'($signed(ins[31:20])); e.op = 2'(opn); e.ill = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3s [3] = '{3'b111, 3'b110, 3'b100};
    logic [2:0] f3 = f3s[$urandom_range(0, 2)];
    logic [4:0] rd = 5'($urandom);
    logic [4:0] r1 = 5'($urandom);
    logic [4:0] r2 = 5'($urandom);
    case ($urandom_range(0, 5))
      0: return {7'b0000000, r2, r1, f3, rd, 7'b0110011};
      1: return {7'b0100000, r2, r1, f3, rd, 7'b0110011};
      2: return {12'($urandom), r1, f3, rd, 7'b0010011};
      3: return 32'($urandom);
      4: return {7'b0000000, r2, r1, 3'($urandom), rd, 7'b0110011};
      default: return {12'($urandom), r1, 3'($urandom), rd, 7'b0010011};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model across the edge, compare #1 later
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic er, input logic rs);
    bit acc;
    bit iss;
    instr_valid = v; instr = ins; rs1_data = r1; rs2_data = r2; ex_ready = er; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ready = 1'b0;
    end else begin
      acc = v && m_ready;
      iss = (q.size() > 0) && er;
      if (iss) q.delete(0);
      if (acc) q.push_back(ref_decode(ins, r1, r2));
      m_ready = (q.size() < 2);
    end
    #1;
    chk("instr_ready", 32'(instr_ready), 32'(m_ready));
    chk("ex_valid", 32'(ex_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("logic_A", logic_A, q[0].a);
      chk("logic_B", logic_B, q[0].b);
      chk("logic_op", 32'(logic_op), 32'(q[0].op));
      chk("rd_addr", 32'(rd_addr), 32'(q[0].rd));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A"}, logic_A, 32'd0);
    chk({tag, "_B"}, logic_B, 32'd0);
    chk({tag, "_op"}, 32'(logic_op), 32'd0);
    chk({tag, "_rd"}, 32'(rd_addr), 32'd0);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
  endtask

  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_XORI = 32'hFFF0C093;
  localparam logic [31:0] I_SLLI = 32'h00001013;
  localparam logic [31:0] I_ANDN = 32'h4020F1B3;

  initial begin
    // Reset held two cycles with valid asserted
    step(1'b1, I_AND, 32'h1, 32'h2, 1'b1, 1'b1);
    step(1'b1, I_AND, 32'h1, 32'h2, 1'b1, 1'b1);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk_zero("rst");
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ready_after_rst", 32'(instr_ready), 32'd1);

    // AND R-type
    step(1'b1, I_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 1'b0);
    chk("and_valid", 32'(ex_valid), 32'd1);
    chk("and_op", 32'(logic_op), 32'd0);
    chk("and_A", logic_A, 32'hF0F0F0F0);
    chk("and_B", logic_B, 32'h0FF00FF0);
    chk("and_rd", 32'(rd_addr), 32'd3);
    chk("and_ill", 32'(illegal), 32'd0);

    // XORI with -1
    step(1'b1, I_XORI, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("xori_op", 32'(logic_op), 32'd2);
    chk("xori_B", logic_B, 32'hFFFFFFFF);
    chk("xori_rd", 32'(rd_addr), 32'd1);

    // Illegal slli, then ANDN with or without the Zbb option
    step(1'b1, I_SLLI, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 1'b0);
    chk("slli_op", 32'(logic_op), 32'd3);
    chk("slli_ill", 32'(illegal), 32'd1);
    chk("slli_A", logic_A, 32'd0);
    chk("slli_B", logic_B, 32'd0);
    step(1'b1, I_ANDN, 32'h11111111, 32'h0000FFFF, 1'b1, 1'b0);
    chk("andn_op", 32'(logic_op), INVB ? 32'd0 : 32'd3);
    chk("andn_B", logic_B, INVB ? 32'hFFFF0000 : 32'd0);
    chk("andn_ill", 32'(illegal), INVB ? 32'd0 : 32'd1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Backpressure: three ORs, third must stall until the skid drains
    step(1'b1, I_OR, 32'h00000001, 32'h00000010, 1'b0, 1'b0);
    step(1'b1, I_OR, 32'h00000002, 32'h00000020, 1'b0, 1'b0);
    chk("bp_ready_low", 32'(instr_ready), 32'd0);
    chk("bp_main_A", logic_A, 32'h00000001);
    step(1'b1, I_OR, 32'h00000003, 32'h00000030, 1'b0, 1'b0);
    chk("bp_hold_A", logic_A, 32'h00000001);
    step(1'b1, I_OR, 32'h00000003, 32'h00000030, 1'b1, 1'b0);
    chk("bp_second_A", logic_A, 32'h00000002);
    step(1'b1, I_OR, 32'h00000003, 32'h00000030, 1'b1, 1'b0);
    chk("bp_third_A", logic_A, 32'h00000003);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_drained", 32'(ex_valid), 32'd0);

    // Mid-operation reset with both entries full
    step(1'b1, I_AND, 32'h0000000A, 32'h0000000B, 1'b0, 1'b0);
    step(1'b1, I_XORI, 32'h0000000C, 32'h0000000D, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk_zero("mid_rst");
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_instr(), 32'($urandom), 32'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
